mdu_iter: RTL



---
 rtl/mdu_iter_pkg.sv | 29 ++
 rtl/mdu_iter_if.sv | 18 +
 rtl/mdu_iter_divstep.sv | 23 ++
 rtl/mdu_iter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// step count, FSM states and the operand-magnitude helper.
package mdu_iter_pkg;

    localparam int unsigned MDU_W     = 32;
    localparam int unsigned MDU_STEPS = 32;
    localparam int unsigned MDU_CNT_W = $clog2(MDU_STEPS);

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } mdu_state_e;

    // Magnitude kept in unsigned bits so 0x80000000 maps to itself exactly.
    function automatic logic [MDU_W-1:0] mdu_mag(input logic [MDU_W-1:0] x,
                                                 input logic              is_signed);
        return (is_signed && x[MDU_W-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Issue/result bundle between decode/stall logic (master) and the MDU (slave).
interface mdu_iter_if
    import mdu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_W
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input  busy, done, hi, lo);
    modport slave  (input  start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter_divstep.sv
// One combinational restoring-divide step: shift in a dividend bit, trial
// subtract the divisor, keep the difference when it does not borrow.
module mdu_divstep
    import mdu_iter_pkg::*;
#(
    parameter int unsigned W = MDU_W
) (
    input  logic [W:0]   i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_div,
    output logic [W:0]   o_rem,
    output logic         o_qbit
);

    logic [W+1:0] w_shift;
    logic [W+2:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = {1'b0, w_shift} - {3'b000, i_div};
    assign o_qbit  = ~w_diff[W+2];
    assign o_rem   = o_qbit ? (W+1)'(w_diff) : (W+1)'(w_shift);

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS32 MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// Optional MDU_CANCEL_EN adds a `cancel` input that flushes an in-flight op.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_W
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef MDU_CANCEL_EN
    input  logic       cancel,
`endif
    mdu_iter_if.slave  bus
);

    localparam int unsigned DW = 2 * WIDTH;

    mdu_state_e           r_state;
    mdu_state_e           w_state_nxt;
    logic [MDU_CNT_W-1:0] r_count;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz;
    logic [WIDTH-1:0]     r_mag;
    logic [DW-1:0]        r_acc;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_can_issue;
    logic                 w_accept;
    logic                 w_mt;
    logic                 w_cancel;
    logic                 w_res_we;
    logic                 w_sgn;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_sum;
    logic [DW-1:0]        w_acc_nxt;
    logic [WIDTH:0]       w_rem_nxt;
    logic                 w_qbit;
    logic [DW-1:0]        w_prod;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    // DONE behaves like IDLE for issue so ops can go back-to-back.
    assign w_can_issue = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept    = w_can_issue && bus.start && (bus.op[2] == 1'b0);
    assign w_mt        = w_can_issue && bus.start &&
                         ((bus.op == MDU_MTHI) || (bus.op == MDU_MTLO));

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel && ((r_state == ST_CALC) || (r_state == ST_FIXUP));
`else
    assign w_cancel = 1'b0;
`endif

    assign w_sgn   = ~bus.op[0];
    assign w_mag_a = mdu_mag(bus.a, w_sgn);
    assign w_mag_b = mdu_mag(bus.b, w_sgn);

    // Shift-add multiply step: add multiplicand to upper half on LSB, shift right.
    assign w_sum     = {1'b0, r_acc[DW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag} : '0);
    assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

    mdu_divstep #(.W(WIDTH)) u_divstep (
        .i_rem  (r_rem),
        .i_bit  (r_quo[WIDTH-1]),
        .i_div  (r_mag),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    // Sign correction; divide-by-zero forces an all-ones quotient, remainder = a.
    assign w_prod    = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix = r_dz ? '1 : (r_neg_q ? -r_quo : r_quo);
    assign w_rem_fix = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_res_we    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: w_state_nxt = w_accept ? ST_CALC : ST_IDLE;
            ST_CALC: begin
                if (r_count == MDU_CNT_W'(MDU_STEPS - 1)) w_state_nxt = ST_FIXUP;
            end
            ST_FIXUP: begin
                w_state_nxt = ST_DONE;
                w_res_we    = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_cancel) begin
            w_state_nxt = ST_IDLE;
            w_res_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_mag    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_CALC) || (w_state_nxt == ST_FIXUP);
            r_done <= w_res_we || w_mt;

            if (w_accept) begin
                r_count  <= '0;
                r_is_div <= bus.op[1];
                r_neg_q  <= w_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_neg_r  <= w_sgn && bus.a[WIDTH-1];
                r_dz     <= (bus.b == '0);
                r_mag    <= bus.op[1] ? w_mag_b : w_mag_a;
                r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                r_rem    <= '0;
                r_quo    <= w_mag_a;
            end else if (r_state == ST_CALC) begin
                r_count <= r_count + 1'b1;
                if (r_is_div) begin
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                end else begin
                    r_acc <= w_acc_nxt;
                end
            end

            if (w_res_we) begin
                if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end else begin
                    r_hi <= w_prod[DW-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end else if (w_mt) begin
                if (bus.op == MDU_MTHI) r_hi <= bus.a;
                else                    r_lo <= bus.a;
            end
        end
    end

endmodule
